// File: rtl/inst_fetch_mem.sv
// rtl/inst_fetch_mem.sv - IF-stage instruction memory with registered fetch, stall/flush and a sequential loader
module inst_fetch_mem #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            pc,
  input  logic                   fetch_en,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   prog_start,
  input  logic [$clog2(DEPTH):0] prog_len,
  input  logic                   prog_valid,
  input  logic [DATA_W-1:0]      prog_data,
  output logic [DATA_W-1:0]      instruction,
  output logic                   inst_valid,
  output logic [31:0]            pc_out,
  output logic                   addr_fault,
  output logic                   loading,
  output logic                   prog_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(4 * DEPTH);
  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

  typedef enum logic {RUN, LOAD} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wcnt_q, wcnt_d;
  logic [AW:0]         len_q, len_d;
  logic                prog_done_q, prog_done_d;
  logic [DATA_W-1:0]   instruction_q, instruction_d;
  logic                inst_valid_q, inst_valid_d;
  logic [31:0]         pc_out_q, pc_out_d;
  logic                addr_fault_q, addr_fault_d;

  logic [DATA_W-1:0]   mem [DEPTH] = '{default: NOP_WORD};
  logic                mem_we;

  logic [32:0]         pc_ext;
  logic [AW-1:0]       index;
  logic                in_range;
  logic [AW:0]         len_clip;
  logic                last_word;

  // 33-bit compare so BASE_ADDR near the top of the address space cannot wrap
  assign pc_ext    = {1'b0, pc};
  assign index     = AW'((pc - BASE_ADDR) >> 2);
  assign in_range  = (pc_ext >= LO_ADDR) && (pc_ext < HI_ADDR) && (pc[1:0] == 2'b00);
  assign len_clip  = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign last_word = ({1'b0, wcnt_q} == (len_q - 1'b1));

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    len_d       = len_q;
    prog_done_d = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      RUN: begin
        if (prog_start && (prog_len != '0)) begin
          state_d = LOAD;
          wcnt_d  = '0;
          len_d   = len_clip;
        end
      end
      LOAD: begin
        if (prog_valid) begin
          mem_we = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (last_word) begin
            state_d     = RUN;
            prog_done_d = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    instruction_d = instruction_q;
    inst_valid_d  = inst_valid_q;
    pc_out_d      = pc_out_q;
    addr_fault_d  = addr_fault_q;
    if (state_q == LOAD || flush) begin
      instruction_d = NOP_WORD;
      inst_valid_d  = 1'b0;
      addr_fault_d  = 1'b0;
    end else if (stall) begin
      instruction_d = instruction_q;
    end else if (fetch_en) begin
      pc_out_d = pc;
      if (in_range) begin
        instruction_d = mem[index];
        inst_valid_d  = 1'b1;
        addr_fault_d  = 1'b0;
      end else begin
        instruction_d = NOP_WORD;
        inst_valid_d  = 1'b0;
        addr_fault_d  = 1'b1;
      end
    end else begin
      instruction_d = NOP_WORD;
      inst_valid_d  = 1'b0;
      addr_fault_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wcnt_q        <= '0;
      len_q         <= '0;
      prog_done_q   <= 1'b0;
      instruction_q <= NOP_WORD;
      inst_valid_q  <= 1'b0;
      pc_out_q      <= '0;
      addr_fault_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      len_q         <= len_d;
      prog_done_q   <= prog_done_d;
      instruction_q <= instruction_d;
      inst_valid_q  <= inst_valid_d;
      pc_out_q      <= pc_out_d;
      addr_fault_q  <= addr_fault_d;
    end
  end

  // Contents survive reset, so the array has no reset branch
  always_ff @(posedge clk) begin
    if (mem_we) mem[wcnt_q] <= prog_data;
  end

  assign instruction = instruction_q;
  assign inst_valid  = inst_valid_q;
  assign pc_out      = pc_out_q;
  assign addr_fault  = addr_fault_q;
  assign loading     = (state_q == LOAD);
  assign prog_done   = prog_done_q;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// tb/tb_inst_fetch_mem.sv - directed and random checks of inst_fetch_mem against a behavioural model
module tb_inst_fetch_mem;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0020;
  localparam logic [31:0] BASE_B = 32'h0000_0400;

  logic clk, reset, fetch_en, stall, flush, prog_start, prog_valid;
  logic [31:0] pc, prog_data;
  logic [AW:0] prog_len;
  logic [31:0] instr_a, pcout_a, instr_b, pcout_b;
  logic valid_a, fault_a, loading_a, done_a;
  logic valid_b, fault_b, loading_b, done_b;

  inst_fetch_mem #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .NOP_WORD(NOP)) dut_a (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .prog_start(prog_start), .prog_len(prog_len), .prog_valid(prog_valid), .prog_data(prog_data),
    .instruction(instr_a), .inst_valid(valid_a), .pc_out(pcout_a), .addr_fault(fault_a),
    .loading(loading_a), .prog_done(done_a));

  inst_fetch_mem #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE_B), .NOP_WORD(NOP)) dut_b (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .prog_start(prog_start), .prog_len(prog_len), .prog_valid(prog_valid), .prog_data(prog_data),
    .instruction(instr_b), .inst_valid(valid_b), .pc_out(pcout_b), .addr_fault(fault_b),
    .loading(loading_b), .prog_done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;

  logic [31:0] mmem [DEPTH];
  logic [31:0] bases [2];
  logic [31:0] e_instr [2];
  logic [31:0] e_pc [2];
  logic        e_valid [2];
  logic        e_fault [2];
  logic        e_done;
  logic        m_load;
  int          m_rem, m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_in_range(input logic [31:0] p, input logic [31:0] b);
    longint lp = longint'(p);
    longint lb = longint'(b);
    return (lp >= lb) && (lp < lb + 4 * DEPTH) && (p % 4 == 0);
  endfunction

  function automatic int ref_index(input logic [31:0] p, input logic [31:0] b);
    return int'(((longint'(p) - longint'(b)) / 4) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      e_instr[k] = NOP; e_valid[k] = 1'b0; e_fault[k] = 1'b0; e_pc[k] = 32'h0;
    end
    e_done = 1'b0;
    m_load = 1'b0;
    m_rem = 0;
    m_ptr = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_load || flush) begin
        e_instr[k] = NOP; e_valid[k] = 1'b0; e_fault[k] = 1'b0;
      end else if (stall) begin
        e_pc[k] = e_pc[k];
      end else if (fetch_en) begin
        e_pc[k] = pc;
        if (ref_in_range(pc, bases[k])) begin
          e_instr[k] = mmem[ref_index(pc, bases[k])]; e_valid[k] = 1'b1; e_fault[k] = 1'b0;
        end else begin
          e_instr[k] = NOP; e_valid[k] = 1'b0; e_fault[k] = 1'b1;
        end
      end else begin
        e_instr[k] = NOP; e_valid[k] = 1'b0; e_fault[k] = 1'b0;
      end
    end
    e_done = 1'b0;
    if (m_load) begin
      if (prog_valid) begin
        mmem[m_ptr] = prog_data;
        m_ptr++;
        m_rem--;
        if (m_rem == 0) begin
          m_load = 1'b0;
          e_done = 1'b1;
        end
      end
    end else if (prog_start && prog_len != 0) begin
      m_load = 1'b1;
      m_rem = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
      m_ptr = 0;
    end
  endtask

  task automatic compare_all();
    check("instr_a", instr_a, e_instr[0]);
    check("valid_a", valid_a, e_valid[0]);
    check("pcout_a", pcout_a, e_pc[0]);
    check("fault_a", fault_a, e_fault[0]);
    check("instr_b", instr_b, e_instr[1]);
    check("valid_b", valid_b, e_valid[1]);
    check("pcout_b", pcout_b, e_pc[1]);
    check("fault_b", fault_b, e_fault[1]);
    check("loading_a", loading_a, m_load);
    check("loading_b", loading_b, m_load);
    check("done_a", done_a, e_done);
    check("done_b", done_b, e_done);
    if (done_a) done_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    reset = 1'b0;
  endtask

  task automatic drive(input logic fe, input logic st, input logic fl, input logic [31:0] p);
    fetch_en = fe; stall = st; flush = fl; pc = p;
  endtask

  task automatic prog_begin(input int len);
    prog_start = 1'b1;
    prog_len = (AW+1)'(len);
    step();
    prog_start = 1'b0;
  endtask

  task automatic prog_word(input logic [31:0] d);
    prog_valid = 1'b1;
    prog_data = d;
    step();
    prog_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] edges [6];
    edges[0] = 32'(4 * DEPTH); edges[1] = 32'(4 * DEPTH - 4); edges[2] = BASE_B - 4;
    edges[3] = BASE_B + 32'(4 * DEPTH); edges[4] = 32'hFFFF_FFFC; edges[5] = 32'h6;
    case ($urandom_range(0, 5))
      0, 1: return 32'($urandom_range(0, DEPTH - 1)) * 4;
      2:    return BASE_B + 32'($urandom_range(0, DEPTH - 1)) * 4;
      3:    return 32'($urandom_range(0, 8 * DEPTH));
      4:    return edges[$urandom_range(0, 5)];
      default: return $urandom();
    endcase
  endfunction

  initial begin
    bases[0] = 32'h0;
    bases[1] = BASE_B;
    for (int i = 0; i < DEPTH; i++) mmem[i] = NOP;
    model_reset();
    reset = 1'b1;
    prog_start = 1'b0; prog_len = '0; prog_valid = 1'b0; prog_data = '0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    check("rst_instr", instr_a, NOP);
    check("rst_pc_out", pcout_a, 32'h0);
    check("rst_loading", loading_a, 1'b0);
    reset = 1'b0;

    prog_begin(2);
    prog_word(32'h2001_0004);
    prog_word(32'h2022_0002);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("pre_rst_instr", instr_a, 32'h2001_0004);
    pulse_reset();
    check("arst_instr", instr_a, NOP);
    check("arst_valid", valid_a, 1'b0);
    step();
    check("f0_instr", instr_a, 32'h2001_0004);
    check("f0_valid", valid_a, 1'b1);
    check("f0_pc", pcout_a, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h4);
    step();
    check("f4_instr", instr_a, 32'h2022_0002);
    check("f4_pc", pcout_a, 32'h4);

    drive(1'b1, 1'b0, 1'b0, 32'(4 * DEPTH));
    step();
    check("oor_fault", fault_a, 1'b1);
    check("oor_valid", valid_a, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h6);
    step();
    check("misal_fault", fault_a, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h3FC);
    step();
    check("base_low_fault", fault_b, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h400);
    step();
    check("base_w0", instr_b, 32'h2001_0004);
    check("base_w0_fault", fault_b, 1'b0);

    drive(1'b1, 1'b0, 1'b0, 32'h8);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'hC);
    repeat (3) begin
      step();
      check("stall_pc", pcout_a, 32'h8);
    end
    drive(1'b1, 1'b1, 1'b1, 32'hC);
    step();
    check("flush_instr", instr_a, NOP);
    check("flush_valid", valid_a, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("bubble_valid", valid_a, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h4);
    step();
    check("after_bubble_valid", valid_a, 1'b1);

    done_seen = 0;
    prog_begin(3);
    check("load_active", loading_a, 1'b1);
    prog_word(32'hA);
    prog_word(32'hB);
    step();
    check("load_gap_active", loading_a, 1'b1);
    prog_word(32'hC);
    check("load_done_pulse", done_a, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("load_done_once", 32'(done_seen), 32'd1);
    check("ld_w0", instr_a, 32'hA);
    drive(1'b1, 1'b0, 1'b0, 32'h4); step(); check("ld_w1", instr_a, 32'hB);
    drive(1'b1, 1'b0, 1'b0, 32'h8); step(); check("ld_w2", instr_a, 32'hC);
    drive(1'b1, 1'b0, 1'b0, 32'hC); step(); check("ld_w3_kept", instr_a, NOP);

    prog_begin(0);
    check("len0_ignored", loading_a, 1'b0);
    prog_begin(DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 5) begin
        prog_start = 1'b1;
        prog_len = (AW+1)'(2);
      end
      prog_word($urandom());
      prog_start = 1'b0;
    end
    check("clip_done", loading_a, 1'b0);
    prog_word(32'hFFFF_FFFF);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'(i * 4));
      step();
    end

    done_seen = 0;
    prog_begin(4);
    prog_word(32'h1111_0000);
    prog_word(32'h2222_0000);
    pulse_reset();
    prog_valid = 1'b1;
    prog_data = 32'h3333_0000;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    prog_valid = 1'b0;
    check("abort_w0", instr_a, 32'h1111_0000);
    drive(1'b1, 1'b0, 1'b0, 32'h4);
    step();
    check("abort_w1", instr_a, 32'h2222_0000);
    check("abort_no_done", 32'(done_seen), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, rand_pc());
      prog_start = ($urandom_range(0, 24) == 0);
      prog_len = (AW+1)'($urandom_range(0, DEPTH + 1));
      prog_valid = $urandom_range(0, 1) == 1;
      prog_data = $urandom();
      step();
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
